// File: rtl/mult_div_unit.sv
// MIPS EX-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as fixed-latency
// multi-cycle ops and MTHI/MTLO as single-cycle writes.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | accepting MDU ops; MTHI/MTLO write here
  // BUSY  | MULT/DIV in flight, counter runs down to the HI/LO commit
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   thi;
  logic [31:0]   tlo;
  logic          twb;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [31:0] div_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        sgn;

  assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign mul_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes and fix signs afterwards; this also makes
  // 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
  // A zero divisor is replaced by 1 only to keep the divider defined;
  // that result is never committed.
  always_comb begin
    sgn   = (op == OP_DIV);
    div_b = (b == 32'd0) ? 32'd1 : b;
    abs_a = a[31] ? (~a + 32'd1) : a;
    abs_b = div_b[31] ? (~div_b + 32'd1) : div_b;
    ua    = sgn ? abs_a : a;
    ub    = sgn ? abs_b : div_b;
    uq    = ua / ub;
    ur    = ua % ub;
    div_q = uq;
    div_r = ur;
    if (sgn && (a[31] ^ b[31])) div_q = ~uq + 32'd1;
    if (sgn && a[31])           div_r = ~ur + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      thi   <= '0;
      tlo   <= '0;
      twb   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !req) begin
            case (op)
              OP_MULT: begin
                {thi, tlo} <= mul_s;
                twb        <= 1'b1;
                cnt        <= CW'(MULT_CYCLES);
                busy       <= 1'b1;
                state      <= BUSY;
              end
              OP_MULTU: begin
                {thi, tlo} <= mul_u;
                twb        <= 1'b1;
                cnt        <= CW'(MULT_CYCLES);
                busy       <= 1'b1;
                state      <= BUSY;
              end
              OP_DIV, OP_DIVU: begin
                thi   <= div_r;
                tlo   <= div_q;
                twb   <= (b != 32'd0);
                cnt   <= CW'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= BUSY;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (twb) begin
              hi <= thi;
              lo <= tlo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random traffic,
// compared every cycle against a cycle-count/arithmetic model of HI/LO/busy.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, req, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural model: an op in flight is just "cycles left" plus the
  // architectural result it will commit (if any).
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res;
  logic        m_wb;
  int          m_left = 0;
  bit          chk_en = 0;

  function automatic logic [63:0] ref_mul(bit sgn, logic [31:0] x, logic [31:0] y);
    longint          p;
    longint unsigned up;
    if (sgn) begin
      p = longint'(signed'(x)) * longint'(signed'(y));
      return p;
    end
    up = longint'(x) * longint'(y);
    return up;
  endfunction

  // Returns {remainder, quotient} = {hi, lo}.
  function automatic logic [63:0] ref_div(bit sgn, logic [31:0] x, logic [31:0] y);
    longint dx, dy, q, r;
    if (sgn) begin
      dx = longint'(signed'(x));
      dy = longint'(signed'(y));
    end else begin
      dx = longint'({32'd0, x});
      dy = longint'({32'd0, y});
    end
    q = dx / dy;
    r = dx % dy;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_wb = 0;
      chk_en = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wb) {m_hi, m_lo} = m_res;
    end else if (start && !req) begin
      case (op)
        3'd0, 3'd1: begin
          m_res = ref_mul(op == 3'd0, a, b); m_wb = 1; m_left = MC;
        end
        3'd2, 3'd3: begin
          m_wb = (b != 0);
          if (m_wb) m_res = ref_div(op == 3'd2, a, b);
          m_left = DC;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic set_in(logic st, logic [2:0] o, logic [31:0] x, logic [31:0] y, logic rq);
    start = st; op = o; a = x; b = y; req = rq;
  endtask

  // Issue one op, then count busy cycles (bounded) until HI/LO are final.
  task automatic run_op(logic [2:0] o, logic [31:0] x, logic [31:0] y, output int n);
    @(negedge clk); set_in(1, o, x, y, 0);
    @(negedge clk); set_in(0, 3'd7, $urandom, $urandom, 0);
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); @(negedge clk); reset = 0;
  endtask

  int n;

  initial begin
    reset = 1; set_in(0, 3'd7, 0, 0, 0);
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, n);
    chk("t1_cycles", n, MC);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFFA);
    chk("t1_model_lo", m_lo, 32'hFFFFFFFA);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, n);
    chk("t2_cycles", n, MC);
    chk("t2_hi", hi, 32'h00000002);
    chk("t2_lo", lo, 32'hFFFFFFFA);
    chk("t2_model_hi", m_hi, 32'h00000002);

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
    chk("t3_cycles", n, DC);
    chk("t3_lo", lo, 32'hFFFFFFFD);
    chk("t3_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'd7, 32'd2, n);
    chk("t3u_lo", lo, 32'd3);
    chk("t3u_hi", hi, 32'd1);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_model_lo", m_lo, 32'h80000000);

    do_reset();
    run_op(3'd4, 32'h1234, 32'd0, n);
    chk("t4_mt_busy", n, 0);
    chk("t4_mthi", hi, 32'h1234);
    run_op(3'd3, 32'd7, 32'd0, n);
    chk("t4_cycles", n, DC);
    chk("t4_hi", hi, 32'h1234);
    chk("t4_lo", lo, 32'd0);

    // MTLO issued during the second busy cycle of a MULT must vanish.
    @(negedge clk); set_in(1, 3'd0, 32'd2, 32'd3, 0);
    @(negedge clk); set_in(0, 3'd7, 0, 0, 0);
    @(negedge clk); set_in(1, 3'd5, 32'hAA, 0, 0);
    @(negedge clk); set_in(0, 3'd7, 32'hDEAD, 32'hBEEF, 0);
    n = 0;
    while (busy && n < 64) begin n++; @(negedge clk); end
    chk("t5_lo", lo, 32'd6);
    chk("t5_hi", hi, 32'd0);

    // req suppresses start.
    @(negedge clk); set_in(1, 3'd0, 32'd5, 32'd5, 1);
    @(negedge clk); set_in(0, 3'd7, 0, 0, 0);
    chk("t6_req_busy", {31'd0, busy}, 32'd0);
    chk("t6_req_lo", lo, 32'd6);

    // req during busy does not abort, and operand changes are ignored.
    @(negedge clk); set_in(1, 3'd1, 32'd7, 32'd9, 0);
    @(negedge clk); set_in(0, 3'd7, 32'd100, 32'd100, 1);
    n = 0;
    while (busy && n < 64) begin n++; @(negedge clk); end
    req = 0;
    chk("req_busy_lo", lo, 32'd63);

    // Reset at busy cycle 4 of a DIV discards it.
    run_op(3'd4, 32'h55, 0, n);
    @(negedge clk); set_in(1, 3'd3, 32'd100, 32'd7, 0);
    @(negedge clk); set_in(0, 3'd7, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t6_b4_busy", {31'd0, busy}, 32'd1);
    reset = 1;
    @(negedge clk); reset = 0;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_hi", hi, 32'd0);
    chk("t6_rst_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    chk("t6_late_hi", hi, 32'd0);
    chk("t6_late_lo", lo, 32'd0);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      start = $urandom_range(0, 1);
      op    = 3'($urandom_range(0, 7));
      a     = ($urandom_range(0, 15) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      req = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); set_in(0, 3'd7, 0, 0, 0); reset = 0;
    repeat (DC + 2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
